// File: rtl/dfswt_bin_tracker_pkg.sv
// dfswt_bin_tracker_pkg: FSM state encoding and default DFT geometry shared by detector and tracker
package dfswt_bin_tracker_pkg;
  localparam int DEF_POINTS = 8;
  localparam int DEF_LOG = 3;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CAND = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
endpackage

// File: rtl/dfswt_valid_delay.sv
// dfswt_valid_delay: delays the sample strobe by the detector latency to mark valid bins
module dfswt_valid_delay #(
  parameter int LAT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic s_vld
);
  logic [LAT-1:0] sr_q, sr_d;
  // shift the strobe in; the oldest stage is the valid flag
  always_comb sr_d = LAT'({sr_q, enable});
  // async clear discards in-flight strobes
  always_ff @(posedge clock or negedge reset)
    if (!reset) sr_q <= '0;
    else sr_q <= sr_d;
  assign s_vld = sr_q[LAT-1];
endmodule

// File: rtl/dfswt_bin_tracker.sv
// dfswt_bin_tracker: persistence hysteresis on the dominant DFT bin with lock/retune/lost events
module dfswt_bin_tracker
  import dfswt_bin_tracker_pkg::*;
#(
  parameter int POINTS = DEF_POINTS,
  parameter int LOG = DEF_LOG,
  parameter int LAT = 2,
  parameter int HOLD = 4,
  parameter int LOSS = 8,
  parameter int CW = 8,
  parameter int IGNORE_DC = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic [LOG-2:0] frequencybin,
  output logic locked,
  output logic [LOG-2:0] bin_out,
  output logic lock_pulse,
  output logic retune_pulse,
  output logic lost_pulse
);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
  localparam logic [CW-1:0] LOSS_C = CW'(LOSS);
  localparam logic [CW-1:0] ONE = CW'(1);
  if (POINTS != (1 << LOG)) begin : g_bad_points
    $error("POINTS must equal 2**LOG");
  end
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return &v ? v : v + ONE;
  endfunction
  logic s_vld;
  logic [1:0] state_q, state_d;
  logic [LOG-2:0] cand_q, cand_d, bin_q, bin_d, alt_q, alt_d;
  logic [CW-1:0] hcnt_q, hcnt_d, miss_q, miss_d, altc_q, altc_d;
  logic locked_q, locked_d, lp_q, lp_d, rp_q, rp_d, lo_q, lo_d;
  logic lockable;
  logic [CW-1:0] hinc, minc, ainc;
  dfswt_valid_delay #(.LAT(LAT)) u_vld (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .s_vld(s_vld)
  );
  // next-state: FSM and counters advance only on valid samples
  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    bin_d = bin_q;
    alt_d = alt_q;
    hcnt_d = hcnt_q;
    miss_d = miss_q;
    altc_d = altc_q;
    lp_d = 1'b0;
    rp_d = 1'b0;
    lo_d = 1'b0;
    lockable = (frequencybin != '0) || (IGNORE_DC == 0);
    hinc = sat_inc(hcnt_q);
    minc = sat_inc(miss_q);
    ainc = (frequencybin == alt_q) ? sat_inc(altc_q) : ONE;
    if (s_vld) begin
      case (state_q)
        IDLE:
          if (lockable) begin
            cand_d = frequencybin;
            hcnt_d = ONE;
            if (HOLD == 1) begin
              state_d = LOCKED;
              bin_d = frequencybin;
              lp_d = 1'b1;
              miss_d = '0;
              altc_d = '0;
            end else state_d = CAND;
          end
        CAND:
          if (frequencybin == cand_q) begin
            hcnt_d = hinc;
            if (hinc >= HOLD_C) begin
              state_d = LOCKED;
              bin_d = cand_q;
              lp_d = 1'b1;
              miss_d = '0;
              altc_d = '0;
            end
          end else if (lockable) begin
            cand_d = frequencybin;
            hcnt_d = ONE;
          end else begin
            state_d = IDLE;
            hcnt_d = '0;
          end
        LOCKED:
          if (frequencybin == bin_q) begin
            miss_d = '0;
            altc_d = '0;
          end else begin
            miss_d = minc;
            if (lockable) begin
              alt_d = frequencybin;
              altc_d = ainc;
            end
            if (lockable && ainc >= HOLD_C) begin
              bin_d = frequencybin;
              rp_d = 1'b1;
              miss_d = '0;
              altc_d = '0;
            end else if (minc >= LOSS_C) begin
              state_d = IDLE;
              lo_d = 1'b1;
              miss_d = '0;
              altc_d = '0;
              hcnt_d = '0;
            end
          end
        default: state_d = IDLE;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end
  // state and registered outputs, async active-low clear
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cand_q <= '0;
      bin_q <= '0;
      alt_q <= '0;
      hcnt_q <= '0;
      miss_q <= '0;
      altc_q <= '0;
      locked_q <= 1'b0;
      lp_q <= 1'b0;
      rp_q <= 1'b0;
      lo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      bin_q <= bin_d;
      alt_q <= alt_d;
      hcnt_q <= hcnt_d;
      miss_q <= miss_d;
      altc_q <= altc_d;
      locked_q <= locked_d;
      lp_q <= lp_d;
      rp_q <= rp_d;
      lo_q <= lo_d;
    end
  assign locked = locked_q;
  assign bin_out = bin_q;
  assign lock_pulse = lp_q;
  assign retune_pulse = rp_q;
  assign lost_pulse = lo_q;
endmodule

// File: tb/tb_dfswt_bin_tracker.sv
// tb_dfswt_bin_tracker: directed vectors for default, HOLD=1 and HOLD=LOSS=4 trackers
module tb_dfswt_bin_tracker;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic [1:0] frequencybin = 2'b00;
  logic [2:0] locked, lock_p, retune_p, lost_p;
  logic [1:0] bin_out [3];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic en;
    logic [1:0] fb;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];

  dfswt_bin_tracker #(.HOLD(4), .LOSS(8)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .frequencybin(frequencybin),
    .locked(locked[0]), .bin_out(bin_out[0]), .lock_pulse(lock_p[0]),
    .retune_pulse(retune_p[0]), .lost_pulse(lost_p[0]));
  dfswt_bin_tracker #(.HOLD(1), .LOSS(8)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .frequencybin(frequencybin),
    .locked(locked[1]), .bin_out(bin_out[1]), .lock_pulse(lock_p[1]),
    .retune_pulse(retune_p[1]), .lost_pulse(lost_p[1]));
  dfswt_bin_tracker #(.HOLD(4), .LOSS(4)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .frequencybin(frequencybin),
    .locked(locked[2]), .bin_out(bin_out[2]), .lock_pulse(lock_p[2]),
    .retune_pulse(retune_p[2]), .lost_pulse(lost_p[2]));

  always #5 clock = ~clock;

  function automatic logic [5:0] e(input logic l, input logic [1:0] b, input logic lp,
                                   input logic rp, input logic lo);
    return {l, b, lp, rp, lo};
  endfunction

  function automatic logic [5:0] obs(input int i);
    return {locked[i], bin_out[i], lock_p[i], retune_p[i], lost_p[i]};
  endfunction

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {locked,bin,lp,rp,lost}=%b required %b", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [1:0] fb, input logic [5:0] exp);
    vec_t v;
    v.en = en;
    v.fb = fb;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic tick(input logic en, input logic [1:0] fb);
    enable = en;
    frequencybin = fb;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    frequencybin = 2'bxx;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clock);
    for (int i = 0; i < 3; i++) chk($sformatf("reset_dut%0d", i), obs(i), 6'b0);
    reset = 1'b1;
    add(1, 2'bxx, e(0, 0, 0, 0, 0));
    add(1, 2'bxx, e(0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) add(1, 3, e(0, 0, 0, 0, 0));
    add(1, 3, e(1, 3, 1, 0, 0));
    add(1, 3, e(1, 3, 0, 0, 0));
    for (int i = 0; i < 7; i++) add(1, (i % 2) ? 2'd2 : 2'd1, e(1, 3, 0, 0, 0));
    add(1, 2, e(0, 3, 0, 0, 1));
    add(1, 0, e(0, 3, 0, 0, 0));
    for (int i = 0; i < 3; i++) add(1, 3, e(0, 3, 0, 0, 0));
    for (int i = 0; i < 3; i++) add(1, 2, e(0, 3, 0, 0, 0));
    add(1, 2, e(1, 2, 1, 0, 0));
    for (int i = 0; i < 3; i++) add(1, 1, e(1, 2, 0, 0, 0));
    add(1, 1, e(1, 1, 0, 1, 0));
    for (int i = 0; i < 7; i++) add(1, 0, e(1, 1, 0, 0, 0));
    add(1, 0, e(0, 1, 0, 0, 1));
    add(1, 3, e(0, 1, 0, 0, 0));
    add(1, 3, e(0, 1, 0, 0, 0));
    add(1, 0, e(0, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) add(1, 3, e(0, 1, 0, 0, 0));
    add(1, 0, e(0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) add(0, 3, e(0, 1, 0, 0, 0));
    add(0, 2'bxx, e(0, 1, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].en, tbl[i].fb);
      chk($sformatf("vec%0d", i), obs(0), tbl[i].exp);
    end

    do_reset();
    tick(1, 2'bxx);
    tick(1, 2'bxx);
    for (int i = 0; i < 3; i++) tick(1, 3);
    chk("hl_pre_lock", obs(2), e(0, 0, 0, 0, 0));
    tick(1, 3);
    chk("hl_lock", obs(2), e(1, 3, 1, 0, 0));
    chk("main_lock2", obs(0), e(1, 3, 1, 0, 0));
    for (int i = 0; i < 3; i++) tick(1, 1);
    chk("hl_pre_retune", obs(2), e(1, 3, 0, 0, 0));
    tick(1, 1);
    chk("hl_retune_wins", obs(2), e(1, 1, 0, 1, 0));
    chk("main_retune", obs(0), e(1, 1, 0, 1, 0));
    tick(1, 1);
    chk("hl_retune_1clk", obs(2), e(1, 1, 0, 0, 0));

    frequencybin = 3;
    #2 reset = 1'b0;
    #1;
    chk("async_reset_main", obs(0), 6'b0);
    chk("async_reset_hl", obs(2), 6'b0);
    @(negedge clock);
    reset = 1'b1;
    tick(0, 3);
    chk("post_reset_main", obs(0), 6'b0);
    chk("post_reset_h1", obs(1), 6'b0);
    tick(1, 3);
    chk("lat_edge1_h1", obs(1), 6'b0);
    tick(1, 3);
    chk("lat_edge2_h1", obs(1), 6'b0);
    tick(1, 3);
    chk("lat_first_sample_h1", obs(1), e(1, 3, 1, 0, 0));

    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick(1, 2'bxx);
      tick(0, 2'bxx);
      tick(0, 3);
      chk($sformatf("sparse%0d_main", k), obs(0), (k < 3) ? e(0, 0, 0, 0, 0) : e(1, 3, 1, 0, 0));
      if (k == 0) chk("sparse_h1_lock", obs(1), e(1, 3, 1, 0, 0));
      tick(0, 2'bxx);
      chk($sformatf("sparse%0d_gap", k), obs(0), (k < 3) ? e(0, 0, 0, 0, 0) : e(1, 3, 0, 0, 0));
      tick(0, 2'bxx);
    end
    chk("sparse_hold_main", obs(0), e(1, 3, 0, 0, 0));
    chk("sparse_hold_h1", obs(1), e(1, 3, 0, 0, 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
